// File: rtl/retire_tracker_if.sv
// Issue-capture and retire-record bundle for retire_tracker.
// The tracker binds to the slave modport; the core/bench side uses master.
interface retire_tracker_if;
  logic        iss_valid;
  logic [31:0] iss_pc;
  logic [31:0] iss_instr;
  logic [5:0]  iss_type;
  logic [4:0]  iss_rd;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;

  // Record handshake: rec_valid is driven only from tracker state and never
  // depends on rec_ready; a record transfers on a rising edge where both are
  // high, and while rec_valid is high without rec_ready the record holds.
  logic        rec_valid;
  logic        rec_ready;
  logic [31:0] rec_pc;
  logic [31:0] rec_instr;
  logic [5:0]  rec_type;
  logic [4:0]  rec_rd;
  logic [4:0]  rec_rs1;
  logic [4:0]  rec_rs2;
  logic [31:0] rec_seq;

  modport master (
    output iss_valid, iss_pc, iss_instr, iss_type, iss_rd, iss_rs1, iss_rs2,
    output rec_ready,
    input  rec_valid, rec_pc, rec_instr, rec_type, rec_rd, rec_rs1, rec_rs2, rec_seq
  );

  modport slave (
    input  iss_valid, iss_pc, iss_instr, iss_type, iss_rd, iss_rs1, iss_rs2,
    input  rec_ready,
    output rec_valid, rec_pc, rec_instr, rec_type, rec_rd, rec_rs1, rec_rs2, rec_seq
  );
endinterface

// File: rtl/retire_tracker.sv
// Shadow pipeline following issued instructions to write-back, emitting ordered
// retire records through a FIFO. Define RETIRE_TRACKER_CHECK_EN for sticky err_sync.
module retire_tracker #(
  parameter int unsigned STAGES     = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_RETIRE = 50
) (
  input  logic               clk,
  input  logic               reset,
  retire_tracker_if.slave    bus,
  input  logic               stall,
  input  logic               flush,
  input  logic               retire,
  output logic [31:0]        retire_count,
  output logic               done,
  output logic               overflow,
  output logic               err_sync
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] MAX_C   = 32'(MAX_RETIRE);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  itype;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } slot_t;

  typedef struct packed {
    slot_t       s;
    logic [31:0] seq;
  } rec_t;

  // ---------------- shadow pipeline ----------------
  slot_t             slot_q [STAGES];
  slot_t             slot_d [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  slot_t             iss_slot;
  logic              hold;
  logic              push;

  assign iss_slot = '{pc:    bus.iss_pc,
                      instr: bus.iss_instr,
                      itype: bus.iss_type,
                      rd:    bus.iss_rd,
                      rs1:   bus.iss_rs1,
                      rs2:   bus.iss_rs2};

  assign hold = flush | stall;
  assign push = retire & vld_q[STAGES-1];

  always_comb begin
    slot_d = slot_q;
    vld_d  = vld_q;
    if (hold) begin
      // Flush kills everything younger than write-back, including this edge's capture.
      if (flush) vld_d[STAGES-2:0] = '0;
      // A held write-back slot that retired must not be retired again.
      if (push) vld_d[STAGES-1] = 1'b0;
    end else begin
      vld_d     = {vld_q[STAGES-2:0], bus.iss_valid};
      slot_d[0] = iss_slot;
      for (int k = 1; k < STAGES; k++) slot_d[k] = slot_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  // ---------------- retire counter / done ----------------
  logic [31:0] cnt_q;
  logic        done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      if (push && (cnt_q != 32'hFFFF_FFFF)) cnt_q <= cnt_q + 32'd1;
      done_q <= done_q | (cnt_q >= MAX_C);
    end
  end

  assign retire_count = cnt_q;
  assign done         = done_q;

  // ---------------- record FIFO ----------------
  rec_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   occ_q;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          ovf_q;
  rec_t          head;

  assign full          = (occ_q == DEPTH_C);
  assign bus.rec_valid = (occ_q != '0);
  assign pop           = bus.rec_valid & bus.rec_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_en         = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= '{s: slot_q[STAGES-1], seq: cnt_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   occ_q <= occ_q + (AW+1)'(1);
        2'b01:   occ_q <= occ_q - (AW+1)'(1);
        default: occ_q <= occ_q;
      endcase
      ovf_q <= ovf_q | (push & full & ~pop);
    end
  end

  assign overflow      = ovf_q;
  assign head          = mem_q[rd_ptr_q];
  assign bus.rec_pc    = head.s.pc;
  assign bus.rec_instr = head.s.instr;
  assign bus.rec_type  = head.s.itype;
  assign bus.rec_rd    = head.s.rd;
  assign bus.rec_rs1   = head.s.rs1;
  assign bus.rec_rs2   = head.s.rs2;
  assign bus.rec_seq   = head.seq;

  // ---------------- protocol checking ----------------
`ifdef RETIRE_TRACKER_CHECK_EN
  logic err_q;
  logic bad_type;

  assign bad_type = bus.iss_valid & ~hold & ~$onehot(bus.iss_type);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_q | (retire & ~vld_q[STAGES-1]) | bad_type;
  end

  assign err_sync = err_q;
`else
  assign err_sync = 1'b0;
`endif

endmodule

// File: tb/tb_retire_tracker.sv
// Directed bench for retire_tracker (STAGES=4, FIFO_DEPTH=8, MAX_RETIRE=50):
// vector table for pipe/stall/flush, hand sequences for overflow, done and reset.
module tb_retire_tracker;

`ifdef RETIRE_TRACKER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall, flush, retire;
  logic [31:0] retire_count;
  logic        done, overflow, err_sync;

  retire_tracker_if bus ();

  retire_tracker #(.STAGES(4), .FIFO_DEPTH(8), .MAX_RETIRE(50)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .stall        (stall),
    .flush        (flush),
    .retire       (retire),
    .retire_count (retire_count),
    .done         (done),
    .overflow     (overflow),
    .err_sync     (err_sync)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded, required completion");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_seq   = 0;
  logic [31:0] model_cnt = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  function automatic logic [5:0] type_of(input logic [31:0] pc);
    return 6'd1 << pc[3:2];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({exp_seq, pc});
    exp_seq++;
  endtask

  task automatic sb_pop();
    logic [63:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got pc 0x%0h seq %0d, required no record",
               bus.rec_pc, bus.rec_seq);
    end else begin
      e = exp_q.pop_front();
      if (bus.rec_pc !== e[31:0] || bus.rec_seq !== e[63:32] ||
          bus.rec_instr !== instr_of(e[31:0]) || bus.rec_type !== type_of(e[31:0]) ||
          bus.rec_rd !== e[6:2] || bus.rec_rs1 !== e[7:3] || bus.rec_rs2 !== e[8:4]) begin
        errors++;
        $display("FAIL sb_record: got pc 0x%0h seq %0d instr 0x%0h type 0x%0h, required pc 0x%0h seq %0d",
                 bus.rec_pc, bus.rec_seq, bus.rec_instr, bus.rec_type, e[31:0], e[63:32]);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [31:0] pc, input logic st,
                       input logic fl, input logic rt, input logic rdy);
    bus.iss_valid = v;
    bus.iss_pc    = pc;
    bus.iss_instr = instr_of(pc);
    bus.iss_type  = type_of(pc);
    bus.iss_rd    = pc[6:2];
    bus.iss_rs1   = pc[7:3];
    bus.iss_rs2   = pc[8:4];
    bus.rec_ready = rdy;
    stall  = st;
    flush  = fl;
    retire = rt;
  endtask

  // One clock: record any handshake away from the edge, then settle after it.
  task automatic step();
    @(negedge clk);
    if (bus.rec_valid && bus.rec_ready) sb_pop();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk({tag, "_count"}, 64'(retire_count), 64'd0);
    chk({tag, "_done"},  64'(done),         64'd0);
    chk({tag, "_rv"},    64'(bus.rec_valid), 64'd0);
    chk({tag, "_ovf"},   64'(overflow),     64'd0);
    chk({tag, "_err"},   64'(err_sync),     64'd0);
    exp_q.delete();
    exp_seq   = 0;
    model_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        st;
    logic        fl;
    logic        rt;
    logic        push;
    logic        exp_rv;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic st,
                              input logic fl, input logic rt, input logic push,
                              input logic erv, input logic [31:0] epc,
                              input logic [31:0] ecnt, input logic eerr);
    vec_t r;
    r = '{v: v, pc: pc, st: st, fl: fl, rt: rt, push: push,
          exp_rv: erv, exp_pc: epc, exp_cnt: ecnt, exp_err: eerr};
    return r;
  endfunction

  vec_t vecs [26];

  initial begin
    //            v  pc        st fl rt push  rv  exp_pc    cnt err
    vecs[0]  = mk(1, 32'h100,  0, 0, 0, 0,    0,  32'h0,    0,  0);
    vecs[1]  = mk(1, 32'h104,  0, 0, 0, 0,    0,  32'h0,    0,  0);
    vecs[2]  = mk(1, 32'h108,  0, 0, 0, 0,    0,  32'h0,    0,  0);
    vecs[3]  = mk(1, 32'h10C,  0, 0, 0, 0,    0,  32'h0,    0,  0);
    vecs[4]  = mk(0, 32'h0,    0, 0, 1, 1,    1,  32'h100,  1,  0);
    vecs[5]  = mk(0, 32'h0,    0, 0, 1, 1,    1,  32'h104,  2,  0);
    vecs[6]  = mk(0, 32'h0,    0, 0, 1, 1,    1,  32'h108,  3,  0);
    vecs[7]  = mk(0, 32'h0,    0, 0, 1, 1,    1,  32'h10C,  4,  0);
    vecs[8]  = mk(0, 32'h0,    0, 0, 0, 0,    0,  32'h0,    4,  0);
    vecs[9]  = mk(1, 32'h200,  0, 0, 0, 0,    0,  32'h0,    4,  0);
    vecs[10] = mk(0, 32'h0,    0, 0, 0, 0,    0,  32'h0,    4,  0);
    vecs[11] = mk(0, 32'h0,    0, 0, 0, 0,    0,  32'h0,    4,  0);
    vecs[12] = mk(0, 32'h0,    0, 0, 0, 0,    0,  32'h0,    4,  0);
    vecs[13] = mk(1, 32'h280,  1, 0, 0, 0,    0,  32'h0,    4,  0);
    vecs[14] = mk(0, 32'h0,    1, 0, 1, 1,    1,  32'h200,  5,  0);
    vecs[15] = mk(0, 32'h0,    1, 0, 1, 0,    0,  32'h0,    5,  CHK);
    vecs[16] = mk(0, 32'h0,    0, 0, 0, 0,    0,  32'h0,    5,  CHK);
    vecs[17] = mk(1, 32'h300,  0, 0, 0, 0,    0,  32'h0,    5,  CHK);
    vecs[18] = mk(1, 32'h304,  0, 0, 0, 0,    0,  32'h0,    5,  CHK);
    vecs[19] = mk(1, 32'h308,  0, 0, 0, 0,    0,  32'h0,    5,  CHK);
    vecs[20] = mk(1, 32'h30C,  0, 0, 0, 0,    0,  32'h0,    5,  CHK);
    vecs[21] = mk(1, 32'h310,  0, 1, 0, 0,    0,  32'h0,    5,  CHK);
    vecs[22] = mk(0, 32'h0,    0, 0, 1, 1,    1,  32'h300,  6,  CHK);
    vecs[23] = mk(0, 32'h0,    0, 0, 1, 0,    0,  32'h0,    6,  CHK);
    vecs[24] = mk(0, 32'h0,    0, 0, 1, 0,    0,  32'h0,    6,  CHK);
    vecs[25] = mk(0, 32'h0,    0, 0, 1, 0,    0,  32'h0,    6,  CHK);

    // ---- reset state ----
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    do_reset("rst0");

    // ---- table: in-order retire, stall without duplicate, flush ----
    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].v, vecs[i].pc, vecs[i].st, vecs[i].fl, vecs[i].rt, 1'b1);
      if (vecs[i].push) push_exp(vecs[i].exp_pc);
      step();
      chk($sformatf("row%0d_rv", i), 64'(bus.rec_valid), 64'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) chk($sformatf("row%0d_pc", i), 64'(bus.rec_pc), 64'(vecs[i].exp_pc));
      chk($sformatf("row%0d_cnt", i), 64'(retire_count), 64'(vecs[i].exp_cnt));
      chk($sformatf("row%0d_err", i), 64'(err_sync), 64'(vecs[i].exp_err));
    end
    chk("tbl_sb_empty", 64'(exp_q.size()), 64'd0);

    // ---- overflow: 9 retires into 8 entries, then full push+pop, then drain ----
    do_reset("rst1");
    for (int c = 0; c < 14; c++) begin
      drive(c < 10, 32'h400 + 32'(4*c), 1'b0, 1'b0, c >= 4, c == 13);
      if (c >= 4) begin
        if (c == 12) exp_seq++;
        else push_exp(32'h400 + 32'(4*(c-4)));
        model_cnt++;
      end
      step();
      if (c == 11) begin
        chk("ovf_full_no_flag", 64'(overflow), 64'd0);
        chk("ovf_full_head", 64'(bus.rec_seq), 64'd0);
      end
      if (c == 12) begin
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(retire_count), 64'd9);
        chk("ovf_head_pc", 64'(bus.rec_pc), 64'h400);
      end
    end
    chk("fullpp_count", 64'(retire_count), 64'd10);
    chk("fullpp_head_seq", 64'(bus.rec_seq), 64'd1);
    chk("fullpp_ovf_sticky", 64'(overflow), 64'd1);
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_rv", 64'(bus.rec_valid), 64'd0);

    // ---- run up to MAX_RETIRE and past it ----
    for (int c = 0; c < 48; c++) begin
      drive(1'b1, 32'h500 + 32'(4*c), 1'b0, 1'b0, c >= 4, 1'b1);
      if (c >= 4) begin
        push_exp(32'h500 + 32'(4*(c-4)));
        model_cnt++;
      end
      step();
      chk($sformatf("run%0d_cnt", c), 64'(retire_count), 64'(model_cnt));
      if (model_cnt == 50) chk("done_lag", 64'(done), 64'd0);
      if (model_cnt == 51) chk("done_set", 64'(done), 64'd1);
    end
    chk("done_hold", 64'(done), 64'd1);
    chk("run_rv", 64'(bus.rec_valid), 64'd1);

    // ---- reset mid-stream, then counting resumes from zero ----
    do_reset("rst2");
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("post_rst_ghost_cnt", 64'(retire_count), 64'd0);
    chk("post_rst_ghost_rv", 64'(bus.rec_valid), 64'd0);
    chk("post_rst_err", 64'(err_sync), 64'(CHK));
    drive(1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    push_exp(32'h600);
    step();
    chk("post_rst_cnt", 64'(retire_count), 64'd1);
    chk("post_rst_seq", 64'(bus.rec_seq), 64'd0);
    chk("post_rst_pc", 64'(bus.rec_pc), 64'h600);
    chk("post_rst_done", 64'(done), 64'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/retire_tracker.md
RETIRE_TRACKER -- requirements
Module: retire_tracker

Interface
REQ-001 SHALL have parameter STAGES, default 4, meaning shadow stages from issue to write-back (legal range 2..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning retire-record FIFO entries (power of two, 2..64).
REQ-003 SHALL have parameter MAX_RETIRE, default 50, meaning retire count that raises done.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port iss_valid/iss_pc/iss_instr  input  1/32/32  meaning issue-stage instruction capture.
REQ-007 SHALL have port iss_type  input  6  meaning one-hot {j,u,b,s,i,r} type, bit0 = r.
REQ-008 SHALL have port iss_rd/iss_rs1/iss_rs2  input  5 each  meaning register indices.
REQ-009 SHALL have port stall  input  1  meaning hold all shadow stages.
REQ-010 SHALL have port flush  input  1  meaning kill all stages except the write-back slot.
REQ-011 SHALL have port retire  input  1  meaning the core retired the write-back instruction this cycle.
REQ-012 SHALL have port rec_valid/rec_ready  output/input  1/1  meaning retire-record handshake.
REQ-013 SHALL have port rec_pc, rec_instr, rec_type, rec_rd, rec_rs1, rec_rs2, rec_seq  output  32,32,6,5,5,5,32  meaning FIFO head record; rec_seq = retire ordinal from 0.
REQ-014 SHALL have port retire_count  output  32, done  output  1, overflow  output  1, err_sync  output  1.

Function
REQ-015 Shadow pipe SHALL shift slot k to slot k+1 every non-stall cycle; slot 0 loads iss_* with valid = iss_valid; slot STAGES-1 is the write-back slot.
REQ-016 With stall=1, all slots SHALL hold; retire is still honoured against the held write-back slot.
REQ-017 flush=1 SHALL clear valid of slots 0..STAGES-2 on that edge, taking priority over shift and stall; the write-back slot is unaffected.
REQ-018 retire=1 with a valid write-back slot SHALL push one record into the FIFO and increment retire_count; rec_seq = pre-increment count.
REQ-019 After a retire with stall=1, the write-back slot SHALL be invalidated so the same instruction cannot retire twice.
REQ-020 FIFO pop SHALL occur when rec_valid && rec_ready; push/pop in the same cycle when full SHALL both succeed and occupancy SHALL be unchanged.
REQ-021 Push when full without a simultaneous pop SHALL drop the record, set overflow sticky; retire_count still increments.
REQ-022 Record latency: a retire at edge N SHALL give rec_valid=1 with that record after edge N when the FIFO was empty, i.e. one cycle.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width is log2(FIFO_DEPTH)+1.
REQ-024 done SHALL assert the cycle after retire_count reaches MAX_RETIRE and stay high until reset; retire_count saturates at 2^32-1.

Reset
REQ-025 reset=0 SHALL asynchronously clear all slot valids, FIFO pointers/occupancy, retire_count, done, overflow and err_sync; rec_valid=0; record data outputs are don't-care.
REQ-026 Reset mid-operation SHALL discard all in-flight slots and FIFO records; counting resumes from 0 after release.

Configuration
REQ-027 Macro RETIRE_TRACKER_CHECK_EN defined: err_sync SHALL set sticky when retire=1 with an invalid write-back slot, or when a valid slot 0 capture has iss_type not one-hot.
REQ-028 Macro RETIRE_TRACKER_CHECK_EN undefined: checking logic SHALL be absent, err_sync tied 0; a retire against an invalid slot is silently ignored.

Verification
REQ-029 STAGES=4: issue pc 0x100..0x10C, one per cycle, retire each 4 cycles later, rec_ready=1 -> records rec_seq 0..3 with matching pc/instr, one cycle after each retire.
REQ-030 stall for 3 cycles with pc 0x200 in write-back, retire on stall cycle 1 -> exactly one record for 0x200, no duplicate.
REQ-031 flush with 0x300 in write-back and 0x304..0x30C younger -> only 0x300 retires; later retire with no valid slot sets err_sync (CHECK_EN) or is ignored (no CHECK_EN).
REQ-032 FIFO_DEPTH=8, rec_ready=0, 9 retires -> 8 records held, overflow=1, retire_count=9; then rec_ready=1 drains seq 0..7.
REQ-033 MAX_RETIRE=50: 50 retires -> done=1 on the following cycle; reset=0 asserted mid-stream clears done, retire_count and rec_valid immediately.
